imm_extend_pipe: RTL and testbench

Parametrised, pipelined immediate extractor/extender for the pipelined LEGv8 datapath. It takes a 32-bit instruction word and a format select, and pulls out the immediate field. It then sign- or zero-extends the field to WIDTH bits, applies the format's scaling (<<2 for branches, <<16·hw for MOVZ/MOVK), and delivers the result through STAGES register stages. Input and output each use a valid/ready handshake, and a synchronous flush clears all in-flight entries. It sits between instruction decode and the ALU/branch operand muxes.

---
 rtl/imm_extend_pipe.sv | 124 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Immediate extractor/extender for the LEGv8 pipeline: decodes the immediate
// field selected by mode, extends and scales it, and carries it through STAGES registers.
`timescale 1ns/1ps

module imm_extend_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] imm,
    output logic             out_err
);

    localparam logic [2:0] MODE_ZERO12 = 3'd0;
    localparam logic [2:0] MODE_SIGN9  = 3'd1;
    localparam logic [2:0] MODE_BR26   = 3'd2;
    localparam logic [2:0] MODE_CB19   = 3'd3;
    localparam logic [2:0] MODE_MOVW   = 3'd4;
    localparam logic [2:0] MODE_SHAMT6 = 3'd5;

    // Bits of the 64-bit intermediate that do not fit in the WIDTH-bit result.
    localparam logic [63:0] HI_MASK = ~((64'd1 << WIDTH) - 64'd1);

    logic [63:0]      movw_shifted;
    logic [63:0]      ext_full;
    logic             ext_illegal;
    logic             ext_err;
    logic [WIDTH-1:0] ext_imm;
    logic             unused_opcode;

    // The opcode bits are decoded upstream and play no part in the immediate.
    assign unused_opcode = ^instr[31:26];

    assign movw_shifted = {48'd0, instr[20:5]} << {instr[22:21], 4'b0000};

    always_comb begin
        ext_full    = '0;
        ext_illegal = 1'b0;
        case (mode)
            MODE_ZERO12: ext_full = {52'd0, instr[21:10]};
            MODE_SIGN9:  ext_full = {{55{instr[20]}}, instr[20:12]};
            MODE_BR26:   ext_full = {{36{instr[25]}}, instr[25:0], 2'b00};
            MODE_CB19:   ext_full = {{43{instr[23]}}, instr[23:5], 2'b00};
            MODE_MOVW:   ext_full = movw_shifted;
            MODE_SHAMT6: ext_full = {58'd0, instr[15:10]};
            default:     ext_illegal = 1'b1;
        endcase
    end

    // Only a MOVW shift can legitimately lose bits; branch offsets simply truncate.
    assign ext_err = ext_illegal | ((mode == MODE_MOVW) & (|(ext_full & HI_MASK)));
    assign ext_imm = ext_full[WIDTH-1:0];

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] err_q;
    logic [WIDTH-1:0]  imm_q [STAGES];

    logic [STAGES-1:0] load;
    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] src_err;
    logic [WIDTH-1:0]  src_imm [STAGES];

    // A stage can load when it or any stage downstream of it has a hole, or the
    // consumer is draining the last stage; this is the ready chain in closed form.
    always_comb begin : ready_chain
        logic chain_full;
        chain_full = 1'b1;
        load       = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain_full = chain_full & valid_q[k];
            load[k]    = out_ready | ~chain_full;
        end
    end

    assign in_ready = load[0] & ~flush;

    always_comb begin
        src_valid    = '0;
        src_err      = '0;
        src_valid[0] = in_valid & in_ready;
        src_err[0]   = ext_err;
        src_imm[0]   = ext_imm;
        for (int k = 1; k < STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_err[k]   = err_q[k-1];
            src_imm[k]   = imm_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                imm_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush) begin
                    valid_q[k] <= 1'b0;
                end else if (load[k]) begin
                    valid_q[k] <= src_valid[k];
                end
                if (load[k]) begin
                    err_q[k] <= src_err[k];
                    imm_q[k] <= src_imm[k];
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_err   = err_q[STAGES-1];
    assign imm       = imm_q[STAGES-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: three instances (64/1, 32/2, 64/3) driven
// with directed vectors; a negedge monitor pops expected results on every output handshake.
`timescale 1ns/1ps

module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  flush;
    logic [2:0]  in_valid;
    logic [2:0]  out_ready;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_err;
    logic [31:0] instr_in [3];
    logic [2:0]  mode_in  [3];
    logic [63:0] imm0;
    logic [31:0] imm1;
    logic [63:0] imm2;

    typedef struct packed {
        logic [63:0] imm;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int compares    = 0;
    int miscompares = 0;
    int last_wait;

    always #5 clk = ~clk;

    imm_extend_pipe #(.WIDTH(64), .STAGES(1)) dut0 (
        .clk(clk), .reset(reset), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .instr(instr_in[0]), .mode(mode_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .imm(imm0), .out_err(out_err[0])
    );

    imm_extend_pipe #(.WIDTH(32), .STAGES(2)) dut1 (
        .clk(clk), .reset(reset), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .instr(instr_in[1]), .mode(mode_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .imm(imm1), .out_err(out_err[1])
    );

    imm_extend_pipe #(.WIDTH(64), .STAGES(3)) dut2 (
        .clk(clk), .reset(reset), .flush(flush[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .instr(instr_in[2]), .mode(mode_in[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .imm(imm2), .out_err(out_err[2])
    );

    function automatic logic [63:0] dutImm(input int d);
        case (d)
            0:       return imm0;
            1:       return {32'd0, imm1};
            default: return imm2;
        endcase
    endfunction

    function automatic int qSize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic pushExp(input int d, input logic [63:0] e_imm, input logic e_err);
        exp_t e;
        e.imm = e_imm;
        e.err = e_err;
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic clearQueue(input int d);
        case (d)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compares++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Pops the oldest outstanding expectation for instance d and compares it.
    task automatic checkOutput(input int d);
        exp_t e;
        if (qSize(d) == 0) begin
            compares++;
            miscompares++;
            $display("[TB] FAIL dut%0d_unexpected: got output imm 0x%0h with nothing outstanding, expected none",
                     d, dutImm(d));
        end else begin
            case (d)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            checkValue($sformatf("dut%0d_imm", d), dutImm(d), e.imm);
            checkValue($sformatf("dut%0d_err", d), {63'd0, out_err[d]}, {63'd0, e.err});
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                if (out_valid[d] && out_ready[d] && !flush[d]) begin
                    checkOutput(d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one entry and holds it until accepted; leaves in_valid high on return.
    task automatic applyStimulus(input int d, input logic [31:0] ins, input logic [2:0] md,
                                 input logic [63:0] e_imm, input logic e_err);
        bit accepted;
        accepted     = 1'b0;
        last_wait    = 0;
        in_valid[d]  = 1'b1;
        instr_in[d]  = ins;
        mode_in[d]   = md;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            if (in_ready[d]) begin
                accepted = 1'b1;
                pushExp(d, e_imm, e_err);
            end else begin
                last_wait++;
            end
            tick();
        end
        if (!accepted) begin
            compares++;
            miscompares++;
            $display("[TB] FAIL dut%0d_accept_timeout: got no accept in 50 cycles, expected accept", d);
        end
    endtask

    task automatic waitDrain(input int d);
        for (int c = 0; c < 100 && qSize(d) != 0; c++) begin
            @(negedge clk);
        end
        tick();
        checkValue($sformatf("dut%0d_drain", d), 64'(qSize(d)), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        flush     = '0;
        in_valid  = '0;
        out_ready = '0;
        for (int d = 0; d < 3; d++) begin
            instr_in[d] = '0;
            mode_in[d]  = '0;
        end
        repeat (2) tick();

        for (int d = 0; d < 3; d++) begin
            checkValue($sformatf("rst%0d_valid", d), {63'd0, out_valid[d]}, 64'd0);
            checkValue($sformatf("rst%0d_err", d), {63'd0, out_err[d]}, 64'd0);
            checkValue($sformatf("rst%0d_imm", d), dutImm(d), 64'd0);
        end
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checkValue($sformatf("rst%0d_ready", d), {63'd0, in_ready[d]}, 64'd1);
        end

        $display("[TB] formats on WIDTH=64 STAGES=1");
        out_ready[0] = 1'b1;
        applyStimulus(0, 32'h003FFC00, 3'd0, 64'h0000000000000FFF, 1'b0);
        applyStimulus(0, 32'hFFFFFFFF, 3'd0, 64'h0000000000000FFF, 1'b0);
        applyStimulus(0, 32'h001F0000, 3'd1, 64'hFFFFFFFFFFFFFFF0, 1'b0);
        applyStimulus(0, 32'h000FF000, 3'd1, 64'h00000000000000FF, 1'b0);
        applyStimulus(0, 32'h03FFFFFF, 3'd2, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        applyStimulus(0, 32'h00000001, 3'd2, 64'h0000000000000004, 1'b0);
        applyStimulus(0, 32'h00000200, 3'd3, 64'h0000000000000040, 1'b0);
        applyStimulus(0, 32'h00FFFFE0, 3'd3, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        applyStimulus(0, 32'h0077DDE0, 3'd4, 64'hBEEF000000000000, 1'b0);
        applyStimulus(0, 32'h00024680, 3'd4, 64'h0000000000001234, 1'b0);
        applyStimulus(0, 32'h0000FC00, 3'd5, 64'h000000000000003F, 1'b0);
        applyStimulus(0, 32'hFFFFFFFF, 3'd7, 64'h0000000000000000, 1'b1);
        applyStimulus(0, 32'h12345678, 3'd6, 64'h0000000000000000, 1'b1);
        in_valid[0] = 1'b0;
        waitDrain(0);

        $display("[TB] truncation on WIDTH=32 STAGES=2");
        out_ready[1] = 1'b1;
        applyStimulus(1, 32'h00424680, 3'd4, 64'h0000000000000000, 1'b1);
        applyStimulus(1, 32'h00224680, 3'd4, 64'h0000000012340000, 1'b0);
        applyStimulus(1, 32'h00600000, 3'd4, 64'h0000000000000000, 1'b0);
        applyStimulus(1, 32'h03FFFFFF, 3'd2, 64'h00000000FFFFFFFC, 1'b0);
        applyStimulus(1, 32'h001F0000, 3'd1, 64'h00000000FFFFFFF0, 1'b0);
        applyStimulus(1, 32'h00024680, 3'd4, 64'h0000000000001234, 1'b0);
        applyStimulus(1, 32'h00000000, 3'd6, 64'h0000000000000000, 1'b1);
        in_valid[1] = 1'b0;
        waitDrain(1);

        $display("[TB] streaming on STAGES=3");
        out_ready[2] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2, (32'h100 + 32'(i)) << 10, 3'd0, 64'h100 + 64'(i), 1'b0);
            checkValue($sformatf("stream_wait_%0d", i), 64'(last_wait), 64'd0);
            if (i < 3) begin
                checkValue($sformatf("stream_valid_%0d", i), {63'd0, out_valid[2]}, (i == 2) ? 64'd1 : 64'd0);
            end
        end
        in_valid[2] = 1'b0;
        waitDrain(2);

        $display("[TB] backpressure on STAGES=2");
        out_ready[1] = 1'b0;
        begin
            int cur;
            logic [31:0] vals [3];
            vals[0] = 32'h11;
            vals[1] = 32'h22;
            vals[2] = 32'h33;
            cur = 0;
            in_valid[1] = 1'b1;
            mode_in[1]  = 3'd5;
            instr_in[1] = vals[0] << 10;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                checkValue($sformatf("bp_ready_%0d", c), {63'd0, in_ready[1]}, (c < 2) ? 64'd1 : 64'd0);
                if (in_ready[1] && cur < 3) begin
                    pushExp(1, 64'(vals[cur]), 1'b0);
                    cur++;
                end
                tick();
                if (cur < 3) begin
                    instr_in[1] = vals[cur] << 10;
                end
                if (c >= 2) begin
                    checkValue($sformatf("bp_hold_valid_%0d", c), {63'd0, out_valid[1]}, 64'd1);
                    checkValue($sformatf("bp_hold_imm_%0d", c), {32'd0, imm1}, 64'h11);
                end
            end
            out_ready[1] = 1'b1;
            @(negedge clk);
            checkValue("bp_accept_on_emit", {63'd0, in_ready[1]}, 64'd1);
            if (in_ready[1] && cur < 3) begin
                pushExp(1, 64'(vals[cur]), 1'b0);
            end
            tick();
            in_valid[1] = 1'b0;
        end
        waitDrain(1);

        $display("[TB] flush on STAGES=3");
        out_ready[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2, (32'h20 + 32'(i)) << 10, 3'd5, 64'h20 + 64'(i), 1'b0);
        end
        checkValue("full_ready", {63'd0, in_ready[2]}, 64'd0);
        checkValue("full_valid", {63'd0, out_valid[2]}, 64'd1);
        instr_in[2] = 32'h0000FC00;
        flush[2]    = 1'b1;
        @(negedge clk);
        checkValue("flush_ready", {63'd0, in_ready[2]}, 64'd0);
        tick();
        flush[2]    = 1'b0;
        in_valid[2] = 1'b0;
        clearQueue(2);
        checkValue("flush_valid", {63'd0, out_valid[2]}, 64'd0);
        out_ready[2] = 1'b1;
        repeat (4) tick();
        checkValue("flush_quiet", {63'd0, out_valid[2]}, 64'd0);
        applyStimulus(2, 32'h001F0000, 3'd1, 64'hFFFFFFFFFFFFFFF0, 1'b0);
        in_valid[2] = 1'b0;
        waitDrain(2);

        $display("[TB] reset mid-stream on STAGES=3");
        out_ready[2] = 1'b0;
        applyStimulus(2, 32'h00000200, 3'd3, 64'h40, 1'b0);
        applyStimulus(2, 32'h00000400, 3'd3, 64'h80, 1'b0);
        in_valid[2] = 1'b0;
        tick();
        checkValue("pre_reset_valid", {63'd0, out_valid[2]}, 64'd1);
        checkValue("pre_reset_imm", imm2, 64'h40);
        reset = 1'b1;
        tick();
        clearQueue(2);
        checkValue("midrst_valid", {63'd0, out_valid[2]}, 64'd0);
        checkValue("midrst_imm", imm2, 64'd0);
        checkValue("midrst_err", {63'd0, out_err[2]}, 64'd0);
        reset = 1'b0;
        checkValue("midrst_ready", {63'd0, in_ready[2]}, 64'd1);
        repeat (2) tick();

        checkValue("final_outstanding", 64'(qSize(0) + qSize(1) + qSize(2)), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", compares, miscompares);
        $finish;
    end

endmodule
